// File: rtl/swchaddr_lookup_engine.sv
// MAC switch address learn/lookup engine.
// Each accepted request first looks up its destination MAC in a direct-mapped
// table, then learns its source MAC against the ingress port. The table lives
// in an external memory with a synchronous write port and a combinational read
// port. A newer entry evicts the old one at the same hash index.
// After reset, and on flush_start, the whole table is cleared.
module swchaddr_lookup_engine #(
    parameter int AWIDTH = 8,
    parameter int PORTW  = 3,
    parameter int DWIDTH = 52
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [47:0]       req_da,
    input  logic [47:0]       req_sa,
    input  logic [PORTW-1:0]  req_port,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_hit,
    output logic [PORTW-1:0]  rsp_port,
    output logic              rsp_flood,
    input  logic              flush_start,
    output logic              flush_busy,
    output logic [15:0]       learn_cnt,
    output logic [AWIDTH-1:0] f0_waddr,
    output logic [DWIDTH-1:0] f0_wdata,
    output logic              f0_write,
    output logic [AWIDTH-1:0] f0_raddr,
    input  logic [DWIDTH-1:0] f0_rdata
);

    // Number of AWIDTH-bit chunks that cover a 48-bit MAC. The top chunk is zero-padded.
    localparam int NCHUNK = (48 + AWIDTH - 1) / AWIDTH;
    localparam int EXTW   = NCHUNK * AWIDTH;
    localparam logic [AWIDTH-1:0] CNT_LAST = {AWIDTH{1'b1}};
    localparam logic [15:0]       CNT_MAX  = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_FLUSH = 3'd0,
        ST_IDLE  = 3'd1,
        ST_LKUP  = 3'd2,
        ST_LEARN = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    // Fold the MAC into AWIDTH-bit chunks, starting at the LSB, and XOR them together.
    function automatic logic [AWIDTH-1:0] mac_hash(input logic [47:0] mac);
        logic [EXTW-1:0]   ext;
        logic [AWIDTH-1:0] h;
        ext = '0;
        ext[47:0] = mac;
        h = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            h = h ^ ext[i*AWIDTH +: AWIDTH];
        end
        return h;
    endfunction

    state_t             state_r;
    state_t             state_s;
    logic [AWIDTH-1:0]  cnt_r;
    logic [47:0]        da_r;
    logic [47:0]        sa_r;
    logic [PORTW-1:0]   iport_r;
    logic               hit_r;
    logic [PORTW-1:0]   eport_r;
    logic [15:0]        learn_cnt_r;

    logic               rd_valid_s;
    logic [47:0]        rd_mac_s;
    logic [PORTW-1:0]   rd_port_s;

    logic               req_ready_s;
    logic               flush_busy_s;
    logic               rsp_valid_s;
    logic               f0_write_s;
    logic [AWIDTH-1:0]  f0_waddr_s;
    logic [DWIDTH-1:0]  f0_wdata_s;
    logic [AWIDTH-1:0]  f0_raddr_s;
    logic               accept_s;
    logic               flush_clr_s;
    logic               lkup_s;
    logic               lkup_hit_s;
    logic               learn_wr_s;

    assign rd_valid_s = f0_rdata[DWIDTH-1];
    assign rd_mac_s   = f0_rdata[PORTW+47:PORTW];
    assign rd_port_s  = f0_rdata[PORTW-1:0];

    // State register. Reset always restarts a full table clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_FLUSH;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state and the memory/handshake strobes that the current state drives.
    always_comb begin
        state_s      = state_r;
        req_ready_s  = 1'b0;
        flush_busy_s = 1'b0;
        rsp_valid_s  = 1'b0;
        f0_write_s   = 1'b0;
        f0_waddr_s   = '0;
        f0_wdata_s   = '0;
        f0_raddr_s   = '0;
        accept_s     = 1'b0;
        flush_clr_s  = 1'b0;
        lkup_s       = 1'b0;
        lkup_hit_s   = 1'b0;
        learn_wr_s   = 1'b0;
        case (state_r)
            ST_FLUSH: begin
                flush_busy_s = 1'b1;
                f0_write_s   = 1'b1;
                f0_waddr_s   = cnt_r;
                if (cnt_r == CNT_LAST) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_FLUSH;
                end
            end
            ST_IDLE: begin
                req_ready_s = ~flush_start;
                if (flush_start) begin
                    flush_clr_s = 1'b1;
                    state_s     = ST_FLUSH;
                end else if (req_valid) begin
                    accept_s = 1'b1;
                    state_s  = ST_LKUP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LKUP: begin
                // Group addresses are never looked up, so they always flood.
                f0_raddr_s = mac_hash(da_r);
                lkup_s     = 1'b1;
                lkup_hit_s = rd_valid_s & (rd_mac_s == da_r) & ~da_r[40];
                state_s    = ST_LEARN;
            end
            ST_LEARN: begin
                // Only a new or changed unicast source is written, so repeat traffic does not rewrite the table.
                f0_raddr_s = mac_hash(sa_r);
                if (~sa_r[40] & (~rd_valid_s | (rd_mac_s != sa_r) | (rd_port_s != iport_r))) begin
                    learn_wr_s = 1'b1;
                    f0_write_s = 1'b1;
                    f0_waddr_s = mac_hash(sa_r);
                    f0_wdata_s = {1'b1, sa_r, iport_r};
                end else begin
                    learn_wr_s = 1'b0;
                end
                state_s = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid_s = 1'b1;
                if (rsp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_FLUSH;
            end
        endcase
    end

    // Flush index, captured request, lookup result and learn counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r       <= '0;
            da_r        <= 48'h0;
            sa_r        <= 48'h0;
            iport_r     <= '0;
            hit_r       <= 1'b0;
            eport_r     <= '0;
            learn_cnt_r <= 16'h0;
        end else begin
            if (flush_busy_s) begin
                cnt_r <= cnt_r + AWIDTH'(1);
            end else if (flush_clr_s) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r;
            end
            if (accept_s) begin
                da_r    <= req_da;
                sa_r    <= req_sa;
                iport_r <= req_port;
            end else begin
                da_r    <= da_r;
                sa_r    <= sa_r;
                iport_r <= iport_r;
            end
            if (lkup_s) begin
                hit_r   <= lkup_hit_s;
                eport_r <= rd_port_s;
            end else begin
                hit_r   <= hit_r;
                eport_r <= eport_r;
            end
            if (learn_wr_s && (learn_cnt_r != CNT_MAX)) begin
                learn_cnt_r <= learn_cnt_r + 16'd1;
            end else begin
                learn_cnt_r <= learn_cnt_r;
            end
        end
    end

    assign req_ready  = req_ready_s;
    assign flush_busy = flush_busy_s;
    assign rsp_valid  = rsp_valid_s;
    assign rsp_hit    = rsp_valid_s & hit_r;
    assign rsp_flood  = rsp_valid_s & ~hit_r;
    assign rsp_port   = rsp_valid_s ? eport_r : '0;
    assign learn_cnt  = learn_cnt_r;
    assign f0_write   = f0_write_s;
    assign f0_waddr   = f0_waddr_s;
    assign f0_wdata   = f0_wdata_s;
    assign f0_raddr   = f0_raddr_s;

endmodule

// File: tb/tb_swchaddr_lookup_engine.sv
// Bench for swchaddr_lookup_engine: a behavioural table memory, a reference
// model of the address table, directed vectors and randomized requests.
module tb_swchaddr_lookup_engine;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [47:0] req_da;
    logic [47:0] req_sa;
    logic [2:0]  req_port;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_hit;
    logic [2:0]  rsp_port;
    logic        rsp_flood;
    logic        flush_start;
    logic        flush_busy;
    logic [15:0] learn_cnt;
    logic [7:0]  f0_waddr;
    logic [51:0] f0_wdata;
    logic        f0_write;
    logic [7:0]  f0_raddr;
    logic [51:0] f0_rdata;

    swchaddr_lookup_engine #(.AWIDTH(8), .PORTW(3), .DWIDTH(52)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_da(req_da), .req_sa(req_sa), .req_port(req_port),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_hit(rsp_hit), .rsp_port(rsp_port), .rsp_flood(rsp_flood),
        .flush_start(flush_start), .flush_busy(flush_busy), .learn_cnt(learn_cnt),
        .f0_waddr(f0_waddr), .f0_wdata(f0_wdata), .f0_write(f0_write),
        .f0_raddr(f0_raddr), .f0_rdata(f0_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Table memory: synchronous write, combinational read, bench poke port.
    logic [51:0] mem [256];
    logic        poke_en;
    logic [7:0]  poke_addr;
    logic [51:0] poke_data;
    always @(posedge clk) begin
        if (poke_en) mem[poke_addr] <= poke_data;
        else if (f0_write) mem[f0_waddr] <= f0_wdata;
    end
    assign f0_rdata = mem[f0_raddr];

    int total;
    int bad;

    // Reference table: what the engine should have learnt.
    bit          ref_v    [256];
    logic [47:0] ref_mac  [256];
    logic [2:0]  ref_port [256];
    logic [15:0] ref_cnt;

    function automatic int ref_hash(input logic [47:0] m);
        int h;
        h = 0;
        for (int i = 0; i < 6; i++) h = h ^ int'((m >> (8 * i)) & 48'hFF);
        return h;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 256; i++) begin
            ref_v[i] = 1'b0; ref_mac[i] = 48'h0; ref_port[i] = 3'd0;
        end
        ref_cnt = 16'd0;
    endtask

    task automatic model_step(input logic [47:0] da, input logic [47:0] sa, input logic [2:0] p,
                              output bit hit, output logic [2:0] hp, output bit wr);
        int hd;
        int hs;
        hd = ref_hash(da);
        hit = ref_v[hd] && (ref_mac[hd] == da) && !da[40];
        hp = ref_port[hd];
        hs = ref_hash(sa);
        wr = !sa[40] && !(ref_v[hs] && (ref_mac[hs] == sa) && (ref_port[hs] == p));
        if (wr) begin
            ref_v[hs] = 1'b1; ref_mac[hs] = sa; ref_port[hs] = p;
            if (ref_cnt != 16'hFFFF) ref_cnt = ref_cnt + 16'd1;
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expects to start #1 after an edge with the engine in FLUSH at index 0.
    task automatic check_flush(input string nm);
        int errs;
        int nz;
        errs = 0;
        for (int idx = 0; idx < 256; idx++) begin
            if (!(flush_busy === 1'b1 && f0_write === 1'b1 && f0_waddr === idx[7:0] &&
                  f0_wdata === 52'h0 && req_ready === 1'b0)) errs++;
            @(posedge clk); #1;
        end
        chk({nm, "_seq_errs"}, 64'(errs), 64'd0);
        chk({nm, "_busy_end"}, 64'(flush_busy), 64'd0);
        chk({nm, "_ready_end"}, 64'(req_ready), 64'd1);
        nz = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== 52'h0) nz++;
        chk({nm, "_mem_nonzero"}, 64'(nz), 64'd0);
    endtask

    // One full request; starts and ends #1 after an edge with the engine in IDLE.
    task automatic do_req(input string nm, input logic [47:0] da, input logic [47:0] sa,
                          input logic [2:0] p, input int hold, input bit e_hit,
                          input logic [2:0] e_port, input bit e_wr, input logic [15:0] e_cnt);
        req_da = da; req_sa = sa; req_port = p; req_valid = 1'b1;
        chk({nm, "_req_ready"}, 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk({nm, "_lkup_raddr"}, {55'd0, rsp_valid, f0_raddr}, 64'(ref_hash(da)));
        @(posedge clk); #1;
        chk({nm, "_learn_raddr"}, 64'(f0_raddr), 64'(ref_hash(sa)));
        chk({nm, "_learn_write"}, 64'(f0_write), 64'(e_wr));
        if (e_wr) begin
            chk({nm, "_waddr"}, 64'(f0_waddr), 64'(ref_hash(sa)));
            chk({nm, "_wdata"}, 64'(f0_wdata), 64'({1'b1, sa, p}));
        end
        @(posedge clk); #1;
        chk({nm, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
        chk({nm, "_rsp_hit_flood"}, {62'd0, rsp_hit, rsp_flood}, {62'd0, e_hit, ~e_hit});
        if (e_hit) chk({nm, "_rsp_port"}, 64'(rsp_port), 64'(e_port));
        for (int h = 0; h < hold; h++) begin
            flush_start = 1'b1;
            @(posedge clk); #1;
            chk({nm, "_hold"}, {59'd0, rsp_valid, rsp_hit, rsp_flood, req_ready, flush_busy},
                {59'd0, 1'b1, e_hit, ~e_hit, 1'b0, 1'b0});
            if (e_hit) chk({nm, "_hold_port"}, 64'(rsp_port), 64'(e_port));
        end
        flush_start = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({nm, "_idle"}, {62'd0, rsp_valid, req_ready}, {62'd0, 1'b0, 1'b1});
        chk({nm, "_learn_cnt"}, 64'(learn_cnt), 64'(e_cnt));
    endtask

    typedef struct {
        logic [47:0] da;
        logic [47:0] sa;
        logic [2:0]  port;
        int          hold;
        bit          e_hit;
        logic [2:0]  e_port;
        bit          e_wr;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t        vecs [8];
    logic [47:0] pool [8];
    bit          m_hit;
    bit          m_wr;
    logic [2:0]  m_port;

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; req_valid = 1'b0; req_da = 48'h0; req_sa = 48'h0; req_port = 3'd0;
        rsp_ready = 1'b0; flush_start = 1'b0;
        poke_en = 1'b0; poke_addr = 8'd0; poke_data = 52'h0;
        model_clear();

        vecs[0] = '{48'h0A00_0000_0001, 48'h0011_2233_4455, 3'd2, 0, 1'b0, 3'd0, 1'b1, 16'd1};
        vecs[1] = '{48'h0011_2233_4455, 48'h0011_2233_4455, 3'd2, 0, 1'b1, 3'd2, 1'b0, 16'd1};
        vecs[2] = '{48'h0A00_0000_0001, 48'h0011_2233_4455, 3'd5, 0, 1'b0, 3'd0, 1'b1, 16'd2};
        vecs[3] = '{48'h0011_2233_4455, 48'h0011_2233_4455, 3'd5, 0, 1'b1, 3'd5, 1'b0, 16'd2};
        vecs[4] = '{48'h0A00_0000_0001, 48'h0000_0000_0101, 3'd1, 0, 1'b0, 3'd0, 1'b1, 16'd3};
        vecs[5] = '{48'h0000_0000_0101, 48'h0000_0000_0202, 3'd3, 0, 1'b1, 3'd1, 1'b1, 16'd4};
        vecs[6] = '{48'h0000_0000_0101, 48'h0011_2233_4455, 3'd5, 0, 1'b0, 3'd0, 1'b0, 16'd4};
        vecs[7] = '{48'h0000_0000_0202, 48'h0011_2233_4455, 3'd5, 5, 1'b1, 3'd3, 1'b0, 16'd4};

        // Fill the memory with garbage while reset is held.
        @(posedge clk); #1;
        for (int i = 0; i < 256; i++) begin
            poke_en = 1'b1; poke_addr = i[7:0]; poke_data = {20'hABCDE, 32'(i) ^ 32'h5A5A_1234};
            @(posedge clk); #1;
        end
        poke_en = 1'b0;
        chk("rst_outputs", {59'd0, flush_busy, req_ready, rsp_valid, rsp_hit, rsp_flood}, {59'd0, 5'b10000});
        chk("rst_learn_cnt", 64'(learn_cnt), 64'd0);
        chk("rst_raddr", 64'(f0_raddr), 64'd0);
        rst_n = 1'b1;
        check_flush("init_flush");

        for (int v = 0; v < 8; v++) begin
            model_step(vecs[v].da, vecs[v].sa, vecs[v].port, m_hit, m_port, m_wr);
            do_req($sformatf("vec%0d", v), vecs[v].da, vecs[v].sa, vecs[v].port, vecs[v].hold,
                   vecs[v].e_hit, vecs[v].e_port, vecs[v].e_wr, vecs[v].e_cnt);
        end

        // Broadcast DA must flood even with a matching table entry; multicast SA never learns.
        poke_en = 1'b1; poke_addr = 8'd0; poke_data = {1'b1, 48'hFFFF_FFFF_FFFF, 3'd3};
        @(posedge clk); #1;
        poke_en = 1'b0;
        ref_v[0] = 1'b1; ref_mac[0] = 48'hFFFF_FFFF_FFFF; ref_port[0] = 3'd3;
        model_step(48'hFFFF_FFFF_FFFF, 48'h0100_5E00_0001, 3'd4, m_hit, m_port, m_wr);
        do_req("bcast", 48'hFFFF_FFFF_FFFF, 48'h0100_5E00_0001, 3'd4, 1, 1'b0, 3'd0, 1'b0, 16'd4);

        // Reset during LEARN: no learn write lands and the flush restarts at 0.
        req_da = 48'h0A00_0000_0001; req_sa = 48'h0000_0077_0033; req_port = 3'd6; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("rstlearn_write_pending", 64'(f0_write), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rstlearn_wdata", 64'(f0_wdata), 64'd0);
        chk("rstlearn_outs", {60'd0, flush_busy, rsp_valid, req_ready, f0_waddr != 8'd0}, {60'd0, 4'b1000});
        chk("rstlearn_cnt", 64'(learn_cnt), 64'd0);
        @(posedge clk); #1;
        chk("rstlearn_mem", 64'(mem[ref_hash(48'h0000_0077_0033)] === {1'b1, 48'h0000_0077_0033, 3'd6}), 64'd0);
        rst_n = 1'b1;
        model_clear();
        check_flush("rst_flush");

        // Learn one entry, then flush_start together with a request: the flush wins.
        model_step(48'h0000_0000_0001, 48'h0000_0000_0444, 3'd1, m_hit, m_port, m_wr);
        do_req("pre_flush", 48'h0000_0000_0001, 48'h0000_0000_0444, 3'd1, 0, 1'b0, 3'd0, 1'b1, 16'd1);
        flush_start = 1'b1; req_valid = 1'b1;
        req_da = 48'h0000_0000_0444; req_sa = 48'h0000_0000_0555; req_port = 3'd2;
        #1;
        chk("flushreq_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        flush_start = 1'b0; req_valid = 1'b0;
        model_clear();
        ref_cnt = 16'd1;
        check_flush("req_flush");

        // Randomized traffic; half the pool collides in pairs on the hash.
        for (int i = 0; i < 4; i++) begin
            pool[i] = {16'($urandom), 32'($urandom)};
            pool[i][40] = 1'b0;
            pool[i + 4] = pool[i] ^ 48'h0000_0000_0101;
        end
        for (int n = 0; n < 40; n++) begin
            logic [47:0] da;
            logic [47:0] sa;
            logic [2:0]  p;
            da = pool[$urandom_range(0, 7)];
            sa = pool[$urandom_range(0, 7)];
            if ($urandom_range(0, 7) == 0) da[40] = 1'b1;
            if ($urandom_range(0, 7) == 0) sa[40] = 1'b1;
            p = 3'($urandom_range(0, 7));
            model_step(da, sa, p, m_hit, m_port, m_wr);
            do_req($sformatf("rnd%0d", n), da, sa, p, $urandom_range(0, 2), m_hit, m_port, m_wr, ref_cnt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
